// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: one write port, two read ports, a reserve port and pending flags.
interface regfile_sb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              ready;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [WIDTH-1:0]  wd3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic              rsv;
  logic [ADDR_W-1:0] rsv_a;
  logic              busy1;
  logic              busy2;

  modport master (
    input  ready, rd1, rd2, busy1, busy2,
    output we3, wa3, wd3, ra1, ra2, rsv, rsv_a
  );

  modport slave (
    output ready, rd1, rd2, busy1, busy2,
    input  we3, wa3, wd3, ra1, ra2, rsv, rsv_a
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, write-through bypass
// and a DEPTH-cycle hardware clear sequence after reset.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NRD   = 2;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [WIDTH-1:0]  r_rf [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic              w_ready;
  logic              w_wr_en;
  logic              w_rsv_en;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == ADDR_W'(DEPTH-1)) w_state_nxt = S_READY;
      S_READY: w_ready = 1'b1;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Register 0 is hard-wired only when ZERO_REG is set.
  assign w_wr_en  = w_ready && bus.we3 && !(ZERO_REG != 0 && bus.wa3 == '0);
  assign w_rsv_en = w_ready && bus.rsv && !(ZERO_REG != 0 && bus.rsv_a == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) r_rf[r_clr_cnt] <= '0;
      else if (w_wr_en)       r_rf[bus.wa3]   <= bus.wd3;
    end
  end

  // Reserve is applied after the write-clear so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      if (w_wr_en)  r_pend[bus.wa3]   <= 1'b0;
      if (w_rsv_en) r_pend[bus.rsv_a] <= 1'b1;
    end
  end

  logic [ADDR_W-1:0] w_ra   [NRD];
  logic [WIDTH-1:0]  w_rd   [NRD];
  logic              w_busy [NRD];

  assign w_ra[0] = bus.ra1;
  assign w_ra[1] = bus.ra2;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic w_zero;
    assign w_zero    = (ZERO_REG != 0) && (w_ra[p] == '0);
    assign w_rd[p]   = (!w_ready || w_zero)             ? '0 :
                       (w_wr_en && bus.wa3 == w_ra[p]) ? bus.wd3 :
                                                          r_rf[w_ra[p]];
    assign w_busy[p] = w_ready & r_pend[w_ra[p]];
  end

  assign bus.ready = w_ready;
  assign bus.rd1   = w_rd[0];
  assign bus.rd2   = w_rd[1];
  assign bus.busy1 = w_busy[0];
  assign bus.busy2 = w_busy[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32 instance plus an 8-bit, 8-entry instance without zero register.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset;
  logic reset8;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .ADDR_W(5)) bus ();
  regfile_sb_if #(.WIDTH(8),  .ADDR_W(3)) bus8 ();

  regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  regfile_sb #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0)) dut8 (
    .clk(clk), .reset(reset8), .bus(bus8.slave));

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic idle();
    bus.we3 = 0; bus.wa3 = '0; bus.wd3 = '0; bus.rsv = 0; bus.rsv_a = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.ra1 = '0; bus.ra2 = '0;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (bus.ready !== 1'b0) begin
        $display("FAIL reset_ready_low cyc=%0d: got %b want 0", i, bus.ready); errs++;
      end
      vecs++;
      @(negedge clk);
    end
    #1;
    if (bus.ready !== 1'b1) begin
      $display("FAIL reset_ready_high: got %b want 1", bus.ready); errs++;
    end
    vecs++;
    for (int a = 0; a < 32; a++) begin
      bus.ra1 = 5'(a); #1;
      if (bus.rd1 !== 32'h0) begin
        $display("FAIL reset_clear rd1[%0d]: got %h want 00000000", a, bus.rd1); errs++;
      end
      vecs++;
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.we3 = 1; bus.wa3 = 5; bus.wd3 = 32'hDEADBEEF; bus.ra1 = 5; bus.ra2 = 6; #1;
    if (bus.rd1 !== 32'hDEADBEEF) begin
      $display("FAIL bypass_same_cycle: got %h want deadbeef", bus.rd1); errs++;
    end
    vecs++;
    if (bus.rd2 !== 32'h0) begin
      $display("FAIL bypass_other_addr: got %h want 00000000", bus.rd2); errs++;
    end
    vecs++;
    @(negedge clk); idle(); #1;
    if (bus.rd1 !== 32'hDEADBEEF) begin
      $display("FAIL write_persist: got %h want deadbeef", bus.rd1); errs++;
    end
    vecs++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    bus.we3 = 1; bus.wa3 = 0; bus.wd3 = 32'hFFFFFFFF; bus.ra2 = 0; #1;
    if (bus.rd2 !== 32'h0) begin
      $display("FAIL zero_same_cycle: got %h want 00000000", bus.rd2); errs++;
    end
    vecs++;
    @(negedge clk); idle(); #1;
    if (bus.rd2 !== 32'h0) begin
      $display("FAIL zero_after: got %h want 00000000", bus.rd2); errs++;
    end
    vecs++;
  endtask

  task automatic test_reserve();
    @(negedge clk);
    bus.rsv = 1; bus.rsv_a = 7; bus.ra1 = 7; bus.ra2 = 0; #1;
    if (bus.busy1 !== 1'b0) begin
      $display("FAIL busy_no_bypass: got %b want 0", bus.busy1); errs++;
    end
    vecs++;
    @(negedge clk); idle(); #1;
    if (bus.busy1 !== 1'b1) begin
      $display("FAIL busy_set: got %b want 1", bus.busy1); errs++;
    end
    vecs++;
    @(negedge clk); bus.we3 = 1; bus.wa3 = 7; bus.wd3 = 32'h0000_1111; #1;
    if (bus.busy1 !== 1'b1) begin
      $display("FAIL busy_write_cycle: got %b want 1", bus.busy1); errs++;
    end
    vecs++;
    @(negedge clk); idle(); #1;
    if (bus.busy1 !== 1'b0) begin
      $display("FAIL busy_cleared: got %b want 0", bus.busy1); errs++;
    end
    vecs++;
    @(negedge clk);
    bus.we3 = 1; bus.wa3 = 7; bus.wd3 = 32'h0000_2222; bus.rsv = 1; bus.rsv_a = 7;
    @(negedge clk); idle(); #1;
    if (bus.busy1 !== 1'b1) begin
      $display("FAIL reserve_wins: got %b want 1", bus.busy1); errs++;
    end
    vecs++;
    if (bus.rd1 !== 32'h0000_2222) begin
      $display("FAIL reserve_wins_data: got %h want 00002222", bus.rd1); errs++;
    end
    vecs++;
    @(negedge clk); bus.rsv = 1; bus.rsv_a = 0;
    @(negedge clk); idle(); #1;
    if (bus.busy2 !== 1'b0) begin
      $display("FAIL zero_reserve: got %b want 0", bus.busy2); errs++;
    end
    vecs++;
    bus.ra2 = 7; #1;
    if (bus.busy2 !== 1'b1) begin
      $display("FAIL busy2_port: got %b want 1", bus.busy2); errs++;
    end
    vecs++;
  endtask

  task automatic test_mid_clear_reset();
    @(negedge clk); bus.we3 = 1; bus.wa3 = 3; bus.wd3 = 32'h12345678; bus.rsv = 1; bus.rsv_a = 9;
    @(negedge clk); idle(); bus.ra1 = 3; #1;
    if (bus.rd1 !== 32'h12345678) begin
      $display("FAIL pre_reset_write: got %h want 12345678", bus.rd1); errs++;
    end
    vecs++;
    reset = 1;
    @(negedge clk); reset = 0;
    repeat (10) @(negedge clk);
    reset = 1; bus.we3 = 1; bus.wa3 = 3; bus.wd3 = 32'hCAFEF00D;
    @(negedge clk); reset = 0; idle();
    for (int i = 0; i < 32; i++) begin
      #1;
      if (bus.ready !== 1'b0) begin
        $display("FAIL midclr_ready_low cyc=%0d: got %b want 0", i, bus.ready); errs++;
      end
      vecs++;
      @(negedge clk);
    end
    #1;
    if (bus.ready !== 1'b1) begin
      $display("FAIL midclr_ready_high: got %b want 1", bus.ready); errs++;
    end
    vecs++;
    bus.ra1 = 3; #1;
    if (bus.rd1 !== 32'h0) begin
      $display("FAIL midclr_rd3: got %h want 00000000", bus.rd1); errs++;
    end
    vecs++;
    for (int a = 0; a < 32; a++) begin
      bus.ra1 = 5'(a); bus.ra2 = 5'(31 - a); #1;
      if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
        $display("FAIL midclr_busy[%0d]: got %b%b want 00", a, bus.busy1, bus.busy2); errs++;
      end
      vecs++;
    end
  endtask

  task automatic test_small_cfg();
    bus8.we3 = 0; bus8.wa3 = '0; bus8.wd3 = '0; bus8.rsv = 0; bus8.rsv_a = '0;
    bus8.ra1 = '0; bus8.ra2 = '0;
    @(negedge clk); reset8 = 1;
    @(negedge clk); reset8 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus8.ready !== 1'b0) begin
        $display("FAIL small_ready_low cyc=%0d: got %b want 0", i, bus8.ready); errs++;
      end
      vecs++;
      @(negedge clk);
    end
    #1;
    if (bus8.ready !== 1'b1) begin
      $display("FAIL small_ready_high: got %b want 1", bus8.ready); errs++;
    end
    vecs++;
    bus8.we3 = 1; bus8.wa3 = 0; bus8.wd3 = 8'hA5; bus8.rsv = 1; bus8.rsv_a = 0; #1;
    if (bus8.rd1 !== 8'hA5) begin
      $display("FAIL small_bypass0: got %h want a5", bus8.rd1); errs++;
    end
    vecs++;
    @(negedge clk); bus8.we3 = 0; bus8.rsv = 0; #1;
    if (bus8.rd1 !== 8'hA5) begin
      $display("FAIL small_reg0: got %h want a5", bus8.rd1); errs++;
    end
    vecs++;
    if (bus8.busy1 !== 1'b1) begin
      $display("FAIL small_busy0: got %b want 1", bus8.busy1); errs++;
    end
    vecs++;
  endtask

  initial begin
    reset = 1; reset8 = 1;
    idle(); bus.ra1 = '0; bus.ra2 = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_reserve();
    test_mid_clear_reset();
    test_small_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2^ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as 0 and ignores writes and reservations.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ready  output  1  high when the clear sequence is complete and the file accepts writes.
REQ-007 SHALL have port we3  input  1  write enable.
REQ-008 SHALL have port wa3  input  ADDR_W  write address.
REQ-009 SHALL have port wd3  input  WIDTH  write data.
REQ-010 SHALL have ports ra1, ra2  input  ADDR_W  read addresses.
REQ-011 SHALL have ports rd1, rd2  output  WIDTH  combinational read data.
REQ-012 SHALL have port rsv  input  1  reserve request (mark a destination pending).
REQ-013 SHALL have port rsv_a  input  ADDR_W  address to reserve.
REQ-014 SHALL have ports busy1, busy2  output  1  pending flag of register at ra1 / ra2.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR, READY; ready = 1 only in READY.
REQ-016 In CLEAR, SHALL write 0 to register index clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, then enter READY the cycle after index DEPTH-1 is written (CLEAR lasts exactly DEPTH cycles).
REQ-017 In CLEAR, SHALL ignore we3 and rsv; rd1, rd2 SHALL read 0 and busy1, busy2 SHALL read 0.
REQ-018 In READY, SHALL write wd3 to rf[wa3] on the rising edge when we3 = 1, except wa3 = 0 with ZERO_REG = 1.
REQ-019 rdN SHALL be 0 when raN = 0 and ZERO_REG = 1; otherwise rf[raN].
REQ-020 SHALL bypass: if ready, we3 = 1, wa3 = raN and the write is not suppressed by REQ-018, rdN SHALL equal wd3 in that same cycle (write-then-read semantics, single edge).
REQ-021 SHALL keep one pending bit per register; rsv = 1 in READY sets pending[rsv_a] on the next edge.
REQ-022 A write per REQ-018 SHALL clear pending[wa3] on the same edge.
REQ-023 If rsv and a write target the same address in one cycle, reserve SHALL win (pending = 1 after the edge).
REQ-024 Reservation of address 0 with ZERO_REG = 1 SHALL be ignored; pending[0] stays 0.
REQ-025 busyN SHALL equal pending[raN] combinationally, with no bypass of same-cycle rsv or write (reflects registered state only).
REQ-026 Width rule: all data paths exactly WIDTH bits; no truncation or extension.

Reset
REQ-027 reset = 1 on a rising edge SHALL force state CLEAR, clr_cnt = 0, all pending bits = 0, ready = 0 on the following cycle.
REQ-028 reset asserted mid-CLEAR SHALL restart clr_cnt at 0; reset in READY SHALL discard pending writes/reservations of that cycle.
REQ-029 While reset is held, SHALL remain in CLEAR with clr_cnt = 0; the DEPTH-cycle clear begins on the first edge with reset = 0.
REQ-030 After reset release and DEPTH cycles, every register SHALL read 0 and ready = 1.

Verification
REQ-031 Reset 1 cycle, release, defaults -> ready = 0 for exactly 32 cycles, then 1; rd1 for ra1 = 0..31 all 0x00000000.
REQ-032 READY: we3 = 1, wa3 = 5, wd3 = 0xDEADBEEF, ra1 = 5 same cycle -> rd1 = 0xDEADBEEF same cycle; next cycle with we3 = 0 still 0xDEADBEEF.
REQ-033 we3 = 1, wa3 = 0, wd3 = 0xFFFFFFFF, ra2 = 0 -> rd2 = 0 in that cycle and after.
REQ-034 rsv = 1, rsv_a = 7; next cycle ra1 = 7 -> busy1 = 1; write wa3 = 7 -> busy1 = 0 next cycle; rsv and write both to 7 same cycle -> busy1 = 1 after.
REQ-035 Write reg 3 = 0x12345678, assert reset 1 cycle after 10 clear cycles of a second reset -> ready stays 0 for 32 cycles from release, rd1(3) = 0, all busy = 0.
REQ-036 WIDTH = 8, ADDR_W = 3, ZERO_REG = 0: write reg 0 = 0xA5 after ready -> rd1(0) = 0xA5; CLEAR lasts 8 cycles.
